// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared nibble decoder,
// blanking gap between digits, frame-synchronous double buffering.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic [3:0]              nibble_out,
    output logic                    dp_out,
    output logic                    blank_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int VW      = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             INACT      = (DIG_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [VW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  dp_q, dp_d;
    logic                  blank_q, blank_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] sel_onehot;

    // Blank from the top digit down while nibble and dp are both zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [VW-1:0]         val,
        input logic [NUM_DIGITS-1:0] dp,
        input logic                  en
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = en;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (run && (val[4*i +: 4] == 4'h0) && !dp[i])
                m[i] = 1'b1;
            else
                run = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            mask_q       <= '0;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            dig_sel_q    <= {NUM_DIGITS{INACT}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            mask_q       <= mask_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d      = BLANK;
                    idx_d        = '0;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The frame_done cycle is the commit cycle; a load landing in it bypasses pending.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        mask_d       = mask_q;
        if (frame_done_q) begin
            if (load) begin
                disp_val_d = value_in;
                disp_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
            mask_d       = lz_mask(disp_val_d, disp_dp_d, lz_blank_en);
        end else if (load) begin
            pend_val_d   = value_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    // The nibble is preloaded during BLANK so it never moves while a digit is lit.
    always_comb begin
        nibble_d   = 4'h0;
        dp_d       = 1'b0;
        blank_d    = 1'b1;
        sel_onehot = '0;
        unique case (state_d)
            BLANK: begin
                nibble_d = disp_val_d[4*idx_d +: 4];
                dp_d     = disp_dp_d[idx_d];
            end
            SHOW: begin
                nibble_d          = disp_val_d[4*idx_d +: 4];
                dp_d              = disp_dp_d[idx_d];
                blank_d           = mask_d[idx_d];
                sel_onehot[idx_d] = 1'b1;
            end
            default: begin
            end
        endcase
        dig_sel_d = sel_onehot ^ {NUM_DIGITS{INACT}};
    end

    assign nibble_out = nibble_q;
    assign dp_out     = dp_q;
    assign blank_out  = blank_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized bench for sevenseg_scan_ctrl against a frame-position model
// (slot = cycle/slot_len arithmetic over a 40-cycle frame).
module tb_sevenseg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int SLOT  = BLK + DIV;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [4*N-1:0] value_in;
    logic [N-1:0]  dp_in;
    logic          lz_blank_en;
    logic [3:0]    nibble_out;
    logic          dp_out;
    logic          blank_out;
    logic [N-1:0]  dig_sel;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic           m_run, m_fd, m_pv;
    int             m_t;
    logic [4*N-1:0] m_disp, m_pend;
    logic [N-1:0]   m_ddp, m_pdp, m_mask;
    logic           prev_lit;
    logic [3:0]     prev_nib;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS(N), .CLK_DIV(DIV),
        .BLANK_CYCLES(BLK), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .value_in(value_in), .dp_in(dp_in), .lz_blank_en(lz_blank_en),
        .nibble_out(nibble_out), .dp_out(dp_out), .blank_out(blank_out),
        .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Digits above the highest significant one are blanked.
    function automatic logic [N-1:0] lz_ref(input logic [4*N-1:0] v,
                                            input logic [N-1:0] dp, input logic en);
        int hs = 0;
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++)
            if (v[4*i +: 4] != 4'h0 || dp[i]) hs = i;
        for (int i = 0; i < N; i++)
            m[i] = en && (i > hs);
        return m;
    endfunction

    task automatic model_edge();
        logic fd_n;
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_fd = 0; m_pv = 0;
            m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_mask = '0;
        end else begin
            if (m_fd) begin
                if (load) begin
                    m_disp = value_in; m_ddp = dp_in;
                end else if (m_pv) begin
                    m_disp = m_pend; m_ddp = m_pdp;
                end
                m_pv   = 0;
                m_mask = lz_ref(m_disp, m_ddp, lz_blank_en);
            end else if (load) begin
                m_pend = value_in; m_pdp = dp_in; m_pv = 1;
            end
            fd_n = enable && (!m_run || m_t == FRAME - 1);
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            m_fd = fd_n;
        end
    endtask

    task automatic check_outputs();
        int d, w;
        logic [N-1:0] exp_sel;
        logic lit;
        exp_sel = '1;
        lit = 0;
        if (m_run) begin
            d = m_t / SLOT;
            w = m_t % SLOT;
            if (w >= BLK) begin
                lit = 1;
                exp_sel = ~(N'(1) << d);
                chk("nibble", nibble_out, m_disp[4*d +: 4]);
                chk("dp_out", dp_out, m_ddp[d]);
                chk("blank_show", blank_out, m_mask[d]);
            end else begin
                chk("blank_gap", blank_out, 1);
            end
        end else begin
            chk("blank_idle", blank_out, 1);
        end
        chk("dig_sel", dig_sel, exp_sel);
        chk("frame_done", frame_done, m_fd);
        chk("onehot", ($countones(~dig_sel) <= 1), 1);
        if (prev_lit && dig_sel != '1)
            chk("nib_stable", nibble_out, prev_nib);
        prev_lit = (dig_sel != '1);
        prev_nib = nibble_out;
        if (lit) prev_lit = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] dp);
        load = 1; value_in = v; dp_in = dp;
        tick();
        load = 0;
    endtask

    task automatic wait_show(input int d);
        logic ok = 0;
        for (int i = 0; i < 4 * FRAME && !ok; i++) begin
            if (m_run && m_t / SLOT == d && m_t % SLOT >= BLK) ok = 1;
            else tick();
        end
        if (!ok) chk("wait_show_timeout", 0, 1);
    endtask

    task automatic wait_fd();
        logic ok = 0;
        for (int i = 0; i < 4 * FRAME && !ok; i++) begin
            if (frame_done) ok = 1;
            else tick();
        end
        if (!ok) chk("wait_fd_timeout", 0, 1);
    endtask

    task automatic check_reset_state();
        chk("rst_nibble", nibble_out, 0);
        chk("rst_dp", dp_out, 0);
        chk("rst_blank", blank_out, 1);
        chk("rst_fd", frame_done, 0);
        chk("rst_dig_sel", dig_sel, 4'hF);
    endtask

    function automatic logic [4*N-1:0] rand_val();
        logic [4*N-1:0] v = 16'($urandom);
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'h0;
        return v;
    endfunction

    initial begin
        int n;
        prev_lit = 0; prev_nib = 0;
        rst_n = 0; enable = 0; load = 0;
        value_in = '0; dp_in = '0; lz_blank_en = 0;
        run(2);
        check_reset_state();

        // start scanning with a load in IDLE
        rst_n = 1; enable = 1;
        do_load(16'h1234, 4'b0000);
        run(FRAME + 5);
        wait_fd();
        n = 0;
        do begin tick(); n++; end while (!frame_done && n < 200);
        chk("fd_period", n, FRAME);

        // mid-frame load lands on the next frame
        wait_show(2);
        do_load(16'hABCD, 4'b0000);
        run(2 * FRAME);

        // last load wins; load in the frame_done cycle commits directly
        wait_show(1);
        do_load(16'h1111, 4'b0001);
        run(3);
        do_load(16'h2222, 4'b0010);
        wait_fd();
        tick();
        wait_fd();
        do_load(16'h5555, 4'b0100);
        run(FRAME);

        // leading-zero blanking
        lz_blank_en = 1;
        do_load(16'h0050, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0000, 4'b1000);
        run(2 * FRAME);

        // enable drop mid-show, then restart
        wait_show(2);
        enable = 0;
        run(5);
        enable = 1;
        run(FRAME + 3);

        // reset mid-show with a pending update
        do_load(16'h9876, 4'b0011);
        wait_show(1);
        rst_n = 0;
        tick();
        check_reset_state();
        rst_n = 1;
        run(2 * FRAME);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            load = ($urandom_range(0, 19) == 0);
            value_in = rand_val();
            dp_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) lz_blank_en = ~lz_blank_en;
            if (enable && $urandom_range(0, 299) == 0) enable = 0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1;
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        load = 0; rst_n = 1;
        run(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-select multi-digit seven-segment display.
- Shares one hex nibble decoder across NUM_DIGITS digits by stepping a digit index, driving the current nibble and decimal point, and enabling one digit-select line at a time.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing); optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- CLK_DIV, 1000, clk cycles a digit is lit per slot (>=1).
- BLANK_CYCLES, 16, clk cycles all digits are off between slots (>=1).
- DIG_ACTIVE_LOW, 1, 1 = dig_sel active-low, 0 = active-high.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  1 = scanning, 0 = display dark
- load  input  1  single-cycle strobe; captures value_in/dp_in into the pending buffer
- value_in  input  4*NUM_DIGITS  hex digits; digit 0 = [3:0] (rightmost)
- dp_in  input  NUM_DIGITS  decimal point per digit
- lz_blank_en  input  1  leading-zero blanking enable
- nibble_out  output  4  nibble to the shared decoder
- dp_out  output  1  decimal point for the current digit
- blank_out  output  1  1 = decoder output must be forced off
- dig_sel  output  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
- frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, counter=0, pending and display buffers=0, pending_valid=0.
  - nibble_out=0, dp_out=0, blank_out=1, frame_done=0, dig_sel all inactive.
  - Reset mid-scan takes effect on the next edge; no partial slot completes.
- States:
  - IDLE: dig_sel inactive, blank_out=1.
    - enable=1: go to BLANK with idx=0, counter=0; this is a frame boundary.
  - BLANK: dig_sel inactive, blank_out=1.
    - After BLANK_CYCLES cycles go to SHOW; counter resets.
  - SHOW: dig_sel[idx] active; nibble_out=display[idx]; dp_out=dp_disp[idx]; blank_out=lz mask bit for idx.
    - After CLK_DIV cycles go to BLANK with idx=idx+1.
    - Wrap: idx=NUM_DIGITS-1 goes to idx=0, and that transition is a frame boundary.
- enable=0 in any state: next edge enters IDLE; outputs go dark the same edge; idx=0.
  - Buffers and pending_valid are kept.
  - Re-enable starts a fresh frame at digit 0.
- Frame boundary:
  - frame_done=1 for exactly one cycle, coincident with entry to BLANK for idx 0.
  - If pending_valid, display/dp_disp take the pending buffer and pending_valid clears.
  - A load in the same cycle as a boundary commits value_in/dp_in directly; pending_valid stays 0.
- Load:
  - load=1 writes the pending buffer and sets pending_valid.
  - Multiple loads within one frame: the last one wins.
  - Load is accepted in every state, including IDLE and during reset release. Reset dominates load.
- Leading-zero blanking:
  - The mask is computed from the display buffer at commit time.
  - With lz_blank_en=1, digits from NUM_DIGITS-1 downward are blanked while their nibble is 0 and dp is 0.
  - Scanning stops at the first nonzero nibble or set dp; digit 0 is never blanked.
  - With lz_blank_en=0, the mask is all 0.
  - lz_blank_en changes apply at the next frame boundary.
- Slot timing: each digit slot is BLANK_CYCLES+CLK_DIV cycles; a frame is NUM_DIGITS*(BLANK_CYCLES+CLK_DIV) cycles.
- Invariants:
  - At most one dig_sel bit is active at any time.
  - dig_sel is never active in the same cycle as a change of nibble_out.

Test Plan:
(NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, DIG_ACTIVE_LOW=1)
- Reset then enable=1, load value_in=16'h1234 in IDLE:
  - frame_done pulses on the first BLANK.
  - Then 2 cycles dig_sel=4'b1111, then 8 cycles dig_sel=4'b1110 with nibble_out=4.
  - Then 2 cycles blank, then dig_sel=4'b1101 with nibble_out=3, and so on.
  - frame_done period = 40 cycles.
- Load 16'hABCD mid-frame at digit 2:
  - Digits 2 and 3 of the current frame still show the old value.
  - The next frame shows D,C,B,A; pending_valid clears at the boundary.
- Two loads in one frame (16'h1111 then 16'h2222), and a separate load coincident with the frame_done cycle (16'h5555):
  - 2222 is displayed next frame.
  - 5555 is visible from digit 0 of the frame starting that cycle.
- lz_blank_en=1, value 16'h0050, dp_in=0:
  - blank_out=1 during SHOW of digits 3 and 2; 0 for digits 1 and 0.
  - Value 16'h0000: only digit 0 is unblanked.
  - dp_in=4'b1000: no digit is blanked.
- enable dropped during SHOW of digit 2:
  - Next edge dig_sel=4'b1111, blank_out=1.
  - Re-enable restarts at digit 0 with a frame_done pulse.
- rst_n=0 during SHOW with pending_valid=1:
  - Next edge all outputs reach reset values and the buffers read 0.
  - Checker confirms one-hot dig_sel throughout all tests.
